// File: rtl/lpddr2_pkg.sv
// ---------------------------------------------------------------------------
// lpddr2_pkg
// Shared types and defaults for the LPDDR2 single-transaction access
// sequencer.
//   lpddr2_state_t      : sequencer state encoding
//   LPDDR2_ADDR_W       : default controller word-address width
//   LPDDR2_TIMEOUT      : default access timeout in mem_clk cycles
//   LPDDR2_ERR_WORD     : default read value returned on an error
//   addr_out_of_range() : 1 when a CPU word address has bits set above the
//                         controller address width
// ---------------------------------------------------------------------------
package lpddr2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } lpddr2_state_t;

  localparam int unsigned LPDDR2_ADDR_W   = 27;
  localparam int unsigned LPDDR2_TIMEOUT  = 1023;
  localparam logic [31:0] LPDDR2_ERR_WORD = 32'hDEAD_BEEF;

  // The CPU side always presents 30 address bits; anything above the
  // controller's width cannot be reached and is flagged instead of aliased.
  function automatic logic addr_out_of_range(input logic [29:0] addr,
                                             input int unsigned  aw);
    logic [29:0] upper;
    upper = addr >> aw;
    return (upper != 30'd0);
  endfunction

endpackage

// File: rtl/lpddr2_timeout.sv
// ---------------------------------------------------------------------------
// lpddr2_timeout
// Saturating up-counter that bounds the time an access may spend on the
// controller bus.
// Ports:
//   clk       : clock (mem_clk)
//   rst       : asynchronous active-high reset
//   i_clr     : synchronous clear (takes priority over i_en)
//   i_en      : count one cycle
//   o_expired : count has reached LIMIT
// ---------------------------------------------------------------------------
module lpddr2_timeout #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned   CW      = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  // Holds at LIMIT so a long stall can never wrap back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIMIT_C);

endmodule

// File: rtl/lpddr2_access_ctrl.sv
// ---------------------------------------------------------------------------
// lpddr2_access_ctrl
// Sequences one word read or write from the CPU memory stage onto the LPDDR2
// controller request/waitrequest/readdatavalid port, returns read data with
// a one-cycle done pulse and aborts any access that outlives TIMEOUT.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for an armed cpu_req; re-arms while cpu_req is low
// ST_RD_ISSUE | read_req high, waiting for waitrequest low
// ST_RD_WAIT  | read accepted by controller, waiting for read_valid
// ST_WR_ISSUE | write_req high, waiting for waitrequest low
// ST_DONE     | cpu_done pulse, back to ST_IDLE next cycle
//
// Ports:
//   mem_clk, rst                  : clock, async active-high reset
//   cpu_req/we/addr/wdata         : memory-stage request (sampled at accept)
//   cpu_rdata/done/busy/err       : memory-stage response (registered)
//   address/write_data            : controller address and write data
//   read_req/write_req            : controller requests (mutually exclusive)
//   read_data/waitrequest/read_valid : controller response
// ---------------------------------------------------------------------------
module lpddr2_access_ctrl
  import lpddr2_pkg::*;
#(
  parameter int unsigned ADDR_W   = LPDDR2_ADDR_W,
  parameter int unsigned TIMEOUT  = LPDDR2_TIMEOUT,
  parameter logic [31:0] ERR_WORD = LPDDR2_ERR_WORD
) (
  input  logic              mem_clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [29:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data,
  output logic              read_req,
  output logic              write_req,
  input  logic              waitrequest,
  input  logic              read_valid
);

  lpddr2_state_t r_state;
  logic          r_armed;

  logic w_accept;
  logic w_oor;
  logic w_tmo_en;
  logic w_tmo_expired;

  assign w_accept = (r_state == ST_IDLE) && cpu_req && r_armed;
  assign w_oor    = addr_out_of_range(cpu_addr, ADDR_W);
  assign w_tmo_en = (r_state == ST_RD_ISSUE) || (r_state == ST_RD_WAIT) ||
                    (r_state == ST_WR_ISSUE);

  lpddr2_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (mem_clk),
    .rst       (rst),
    .i_clr     (w_accept),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_expired)
  );

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b1;
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      cpu_busy   <= 1'b0;
      cpu_err    <= 1'b0;
      address    <= '0;
      write_data <= '0;
      read_req   <= 1'b0;
      write_req  <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // armed only clears on acceptance, so a request level held across
          // DONE is not reissued until the memory stage drops it.
          if (!cpu_req) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed  <= 1'b0;
            cpu_err  <= 1'b0;
            cpu_busy <= 1'b1;
            if (w_oor) begin
              r_state  <= ST_DONE;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
              if (!cpu_we) begin
                cpu_rdata <= ERR_WORD;
              end
            end else if (cpu_we) begin
              address    <= cpu_addr[ADDR_W-1:0];
              write_data <= cpu_wdata;
              write_req  <= 1'b1;
              r_state    <= ST_WR_ISSUE;
            end else begin
              address  <= cpu_addr[ADDR_W-1:0];
              read_req <= 1'b1;
              r_state  <= ST_RD_ISSUE;
            end
          end
        end

        ST_RD_ISSUE: begin
          if (w_tmo_expired) begin
            read_req  <= 1'b0;
            cpu_rdata <= ERR_WORD;
            cpu_err   <= 1'b1;
            cpu_done  <= 1'b1;
            r_state   <= ST_DONE;
          end else if (!waitrequest) begin
            read_req <= 1'b0;
            r_state  <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          // Data arriving on the expiry edge is still good, so it wins.
          if (read_valid) begin
            cpu_rdata <= read_data;
            cpu_done  <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_tmo_expired) begin
            cpu_rdata <= ERR_WORD;
            cpu_err   <= 1'b1;
            cpu_done  <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_WR_ISSUE: begin
          if (w_tmo_expired) begin
            write_req <= 1'b0;
            cpu_err   <= 1'b1;
            cpu_done  <= 1'b1;
            r_state   <= ST_DONE;
          end else if (!waitrequest) begin
            write_req <= 1'b0;
            cpu_done  <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          cpu_busy <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          read_req  <= 1'b0;
          write_req <= 1'b0;
          cpu_busy  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr2_access_ctrl.sv
module tb_lpddr2_access_ctrl;

  localparam int          AW   = 27;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [29:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_done;
  logic          cpu_busy;
  logic          cpu_err;
  logic [AW-1:0] address;
  logic [31:0]   write_data;
  logic [31:0]   read_data = '0;
  logic          read_req;
  logic          write_req;
  logic          waitrequest = 1'b0;
  logic          read_valid = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   rd_issues = 0;
  int   wr_issues = 0;
  int   wr_high_cycles = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic [31:0] model_rdata = '0;
  exp_t sb_q[$];

  lpddr2_access_ctrl #(
    .ADDR_W   (AW),
    .TIMEOUT  (TMO),
    .ERR_WORD (ERRW)
  ) dut (
    .mem_clk     (mem_clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .cpu_busy    (cpu_busy),
    .cpu_err     (cpu_err),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .read_req    (read_req),
    .write_req   (write_req),
    .waitrequest (waitrequest),
    .read_valid  (read_valid)
  );

  always #5 mem_clk = ~mem_clk;

  // Bus monitor: counts request issues and checks exclusivity.
  always begin
    @(posedge mem_clk);
    #1;
    if (read_req && !prev_rd) rd_issues++;
    if (write_req && !prev_wr) wr_issues++;
    if (write_req) wr_high_cycles++;
    if (read_req || write_req) begin
      checks++;
      if (read_req && write_req) begin
        failures++;
        $display("FAIL req_exclusive: read_req=%0b write_req=%0b, required not both", read_req, write_req);
      end
    end
    prev_rd = read_req;
    prev_wr = write_req;
  end

  task automatic check_all_zero(input string name);
    checks++;
    if ({cpu_rdata, cpu_done, cpu_busy, cpu_err, address, write_data, read_req, write_req} !== '0) begin
      failures++;
      $display("FAIL %s: rdata=%h done=%b busy=%b err=%b addr=%h wdata=%h rreq=%b wreq=%b, required all 0",
               name, cpu_rdata, cpu_done, cpu_busy, cpu_err, address, write_data, read_req, write_req);
    end
  endtask

  // One CPU transaction. valid_edge = edge (relative to acceptance) at which
  // read_valid is presented, 0 = never. hold = cycles cpu_req stays high after done.
  task automatic run_txn(input string name, input logic we, input logic [29:0] addr,
                         input logic [31:0] wdata, input int stall, input int valid_edge,
                         input logic [31:0] bus_data, input logic exp_err, input int exp_lat,
                         input int hold);
    exp_t e;
    exp_t got;
    int   rd0;
    int   wr0;
    int   exp_rd_d;
    int   exp_wr_d;
    logic oor;
    logic [29:0] upper;
    bit   seen;
    upper = addr >> AW;
    oor = (upper != 30'd0);
    e.err = exp_err;
    e.lat = exp_lat;
    if (we) e.rdata = model_rdata;
    else if (exp_err) e.rdata = ERRW;
    else e.rdata = bus_data;
    model_rdata = e.rdata;
    sb_q.push_back(e);
    exp_rd_d = (!we && !oor) ? 1 : 0;
    exp_wr_d = (we && !oor) ? 1 : 0;
    rd0 = rd_issues;
    wr0 = wr_issues;
    @(negedge mem_clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    waitrequest = 1'b0; read_valid = 1'b0;
    seen = 0;
    for (int j = 0; j < 40 && !seen; j++) begin
      @(negedge mem_clk);
      if (j == 0) begin
        checks++;
        if (cpu_busy !== 1'b1) begin
          failures++;
          $display("FAIL %s_busy: got %b, required 1", name, cpu_busy);
        end
        if (!oor) begin
          checks++;
          if ({read_req, write_req} !== {~we, we}) begin
            failures++;
            $display("FAIL %s_req: rd/wr got %b%b, required %b%b", name, read_req, write_req, ~we, we);
          end
          checks++;
          if (address !== addr[AW-1:0]) begin
            failures++;
            $display("FAIL %s_addr: got %h, required %h", name, address, addr[AW-1:0]);
          end
          if (we) begin
            checks++;
            if (write_data !== wdata) begin
              failures++;
              $display("FAIL %s_wdata: got %h, required %h", name, write_data, wdata);
            end
          end
        end
      end
      if (cpu_done === 1'b1) begin
        seen = 1;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s_sb: done with empty scoreboard", name);
        end else begin
          got = sb_q.pop_front();
          if (cpu_rdata !== got.rdata || cpu_err !== got.err || (j + 1) != got.lat) begin
            failures++;
            $display("FAIL %s_result: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                     name, cpu_rdata, cpu_err, j + 1, got.rdata, got.err, got.lat);
          end
        end
        checks++;
        if ({read_req, write_req} !== 2'b00) begin
          failures++;
          $display("FAIL %s_req_drop: rd/wr got %b%b, required 00", name, read_req, write_req);
        end
      end else begin
        waitrequest = (j < stall);
        read_valid  = ((j + 1) == valid_edge);
        read_data   = read_valid ? bus_data : 32'h0BAD_0BAD;
      end
    end
    waitrequest = 1'b0;
    read_valid = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_no_done: no cpu_done within 40 cycles, required latency %0d", name, exp_lat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    checks++;
    if ((rd_issues - rd0) != exp_rd_d || (wr_issues - wr0) != exp_wr_d) begin
      failures++;
      $display("FAIL %s_issues: rd=%0d wr=%0d, required rd=%0d wr=%0d",
               name, rd_issues - rd0, wr_issues - wr0, exp_rd_d, exp_wr_d);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge mem_clk);
      checks++;
      if ((rd_issues - rd0) != exp_rd_d || (wr_issues - wr0) != exp_wr_d || cpu_busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold: rd=%0d wr=%0d busy=%b, required rd=%0d wr=%0d busy=0",
                 name, rd_issues - rd0, wr_issues - wr0, cpu_busy, exp_rd_d, exp_wr_d);
      end
    end
    cpu_req = 1'b0;
    @(negedge mem_clk);
    checks++;
    if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: done=%b busy=%b, required 0 0", name, cpu_done, cpu_busy);
    end
  endtask

  task automatic test_reset();
    #12;
    check_all_zero("reset_values");
    @(negedge mem_clk);
    rst = 1'b0;
    model_rdata = '0;
  endtask

  task automatic test_read_basic();
    run_txn("rd_basic", 1'b0, 30'h10, 32'h0, 0, 2, 32'h1234_5678, 1'b0, 3, 0);
  endtask

  task automatic test_write_stall();
    int w0;
    w0 = wr_high_cycles;
    run_txn("wr_stall", 1'b1, 30'h20, 32'hCAFE_F00D, 3, 0, 32'h0, 1'b0, 5, 0);
    checks++;
    if ((wr_high_cycles - w0) != 4) begin
      failures++;
      $display("FAIL wr_stall_req_cycles: got %0d, required 4", wr_high_cycles - w0);
    end
  endtask

  task automatic test_back_to_back();
    run_txn("hold_first", 1'b0, 30'h30, 32'h0, 0, 2, 32'h1111_2222, 1'b0, 3, 20);
    run_txn("hold_second", 1'b0, 30'h31, 32'h0, 1, 3, 32'h3333_4444, 1'b0, 4, 0);
  endtask

  task automatic test_out_of_range();
    run_txn("oor_rd", 1'b0, 30'h0800_0000, 32'h0, 0, 0, 32'h0, 1'b1, 1, 0);
    run_txn("oor_wr", 1'b1, 30'h2000_0010, 32'h0000_0001, 0, 0, 32'h0, 1'b1, 1, 0);
    run_txn("wr_after_err", 1'b1, 30'h24, 32'h0102_0304, 0, 0, 32'h0, 1'b0, 2, 0);
    run_txn("rd_top_addr", 1'b0, 30'h07FF_FFFF, 32'h0, 2, 6, 32'h89AB_CDEF, 1'b0, 7, 0);
  endtask

  task automatic test_timeout();
    run_txn("tmo_rd_wait", 1'b0, 30'h50, 32'h0, 0, 0, 32'h7777_7777, 1'b1, TMO + 2, 0);
    @(negedge mem_clk);
    read_valid = 1'b1;
    read_data = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge mem_clk);
      checks++;
      if (cpu_done !== 1'b0 || cpu_rdata !== ERRW) begin
        failures++;
        $display("FAIL tmo_late_valid: done=%b rdata=%h, required done=0 rdata=%h", cpu_done, cpu_rdata, ERRW);
      end
    end
    read_valid = 1'b0;
    run_txn("tmo_coincide", 1'b0, 30'h51, 32'h0, 0, TMO + 1, 32'h600D_DA7A, 1'b0, TMO + 2, 0);
    run_txn("tmo_rd_issue", 1'b0, 30'h52, 32'h0, 100, 0, 32'h0, 1'b1, TMO + 2, 0);
    run_txn("tmo_wr", 1'b1, 30'h53, 32'h0000_ABCD, 100, 0, 32'h0, 1'b1, TMO + 2, 0);
  endtask

  task automatic test_reset_mid_access();
    @(negedge mem_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h44;
    waitrequest = 1'b0;
    @(negedge mem_clk);
    @(negedge mem_clk);
    checks++;
    if (read_req !== 1'b0 || cpu_busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: read_req=%b busy=%b, required 0 1", read_req, cpu_busy);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("rstmid_async");
    cpu_req = 1'b0;
    @(negedge mem_clk);
    rst = 1'b0;
    model_rdata = '0;
    // reset while a write request is stalled drops write_req at once
    @(negedge mem_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h45; cpu_wdata = 32'h9999_0000;
    waitrequest = 1'b1;
    @(negedge mem_clk);
    #2 rst = 1'b1;
    #1 check_all_zero("rstmid_wr_async");
    cpu_req = 1'b0;
    waitrequest = 1'b0;
    @(negedge mem_clk);
    rst = 1'b0;
    run_txn("rd_after_rst", 1'b0, 30'h46, 32'h0, 0, 2, 32'h0F0F_1234, 1'b0, 3, 0);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_back_to_back();
    test_out_of_range();
    test_timeout();
    test_reset_mid_access();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d entries, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpddr2_access_ctrl.md
# lpddr2_access_ctrl

Single-transaction sequencer between the CPU memory stage and the LPDDR2 controller port. It accepts one word read or write from the memory stage, then drives the controller's request/waitrequest/readdatavalid handshake. It returns read data with a one-cycle done pulse and bounds every access with a timeout. It runs entirely on `mem_clk`, so a full access completes well within one CPU `clk` phase.

## Interface
Parameters:
- `ADDR_W`, 27: LPDDR2 word-address width.
- `TIMEOUT`, 1023: maximum `mem_clk` cycles spent in the issue and wait states combined before the access is aborted.
- `ERR_WORD`, 32'hDEAD_BEEF: value returned on an aborted or out-of-range read.

Ports:
- Clock and reset: one clock, `mem_clk`. Reset `rst` is asynchronous and active-high.
- `mem_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  level request; held by the memory stage until `cpu_done`.
- `cpu_we`  in  1  1 = write, 0 = read; sampled at acceptance.
- `cpu_addr`  in  30  word address; sampled at acceptance.
- `cpu_wdata`  in  32  write data; sampled at acceptance.
- `cpu_rdata`  out  32  read result; held until the next accepted read.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_busy`  out  1  high from acceptance through the `DONE` cycle.
- `cpu_err`  out  1  high with `cpu_done` on timeout or out-of-range; cleared at the next acceptance.
- `address`  out  ADDR_W  controller word address.
- `write_data`  out  32  controller write data.
- `read_data`  in  32  controller read data.
- `read_req`  out  1  controller read request.
- `write_req`  out  1  controller write request.
- `waitrequest`  in  1  controller stall; a request is accepted at an edge where it is low.
- `read_valid`  in  1  `read_data` is valid this cycle.

## Operation
- States: `IDLE`, `RD_ISSUE`, `RD_WAIT`, `WR_ISSUE`, `DONE`. All outputs are registered.
- Reset: state is `IDLE`, `armed`=1, and all outputs are 0, including `cpu_rdata`, `address` and `write_data`. Reset mid-access drops `read_req`/`write_req` immediately and discards the access.
- Acceptance: in `IDLE`, when `cpu_req`=1 and `armed`=1, the block latches `cpu_we`, `cpu_addr` and `cpu_wdata`, then clears `armed` and `cpu_err`.
- Re-arming: `armed` is set in `IDLE` when `cpu_req`=0. A level request held across `DONE` is never issued twice.
- Out-of-range: if `cpu_addr[29:ADDR_W]` is non-zero, the block goes `IDLE`→`DONE` with `cpu_err`=1. There is no bus activity. A read returns `cpu_rdata`=`ERR_WORD`; a write is dropped.
- Read path: `IDLE`→`RD_ISSUE`, with `read_req`=1 and `address`=`cpu_addr[ADDR_W-1:0]`.
  - At an edge with `waitrequest`=0, the block moves to `RD_WAIT` and drops `read_req`.
  - At an edge with `read_valid`=1, it captures `read_data` into `cpu_rdata` and moves to `DONE`.
- Write path: `IDLE`→`WR_ISSUE`, with `write_req`=1, `address` and `write_data` valid. At an edge with `waitrequest`=0, the block moves to `DONE` and drops `write_req`.
- `DONE`: `cpu_done`=1 for exactly one cycle, then the block returns to `IDLE`.
- Timeout counter:
  - It clears at acceptance and increments each cycle in `RD_ISSUE`, `RD_WAIT` and `WR_ISSUE`.
  - When it reaches `TIMEOUT`, the block drops its request, goes to `DONE` with `cpu_err`=1, and a read returns `ERR_WORD`.
  - The counter saturates and never wraps.
- Stray `read_valid` outside `RD_WAIT` is ignored. A `read_valid` that coincides with the timeout edge wins: the data is captured and `cpu_err`=0.
- `read_req` and `write_req` are never high together.

## Timing
- Acceptance at edge k. The request is visible after k; the earliest controller acceptance is edge k+1.
- Write, `waitrequest` low: `cpu_done` is high in the cycle after k+1, so minimum latency is 2 cycles.
- Read, `waitrequest` low and `read_valid` at edge k+2: `cpu_done` and `cpu_rdata` are valid after k+2, so minimum latency is 3 cycles.
- Earliest re-acceptance is one cycle after `cpu_done` falls, and only once `cpu_req` has been seen low.
- Each stall cycle adds one cycle of latency. Worst case before abort: `TIMEOUT`+2 cycles.

## Structure
- Package `lpddr2_pkg`: state enum `lpddr2_state_t`, default `ERR_WORD`, default `ADDR_W`, default `TIMEOUT`.
- Sub-module `lpddr2_timeout`: saturating counter with clear, enable and `expired` outputs.
- The FSM, `armed` flag and data latches sit in the top level.

## Test plan
- Read of `cpu_addr`=0x10, `waitrequest`=0, `read_valid` with 0x1234_5678 at edge k+2 -> `address`=0x10, `cpu_rdata`=0x1234_5678, `cpu_done` one cycle after k+2, `cpu_err`=0.
- Write of 0xCAFE_F00D to 0x20 with `waitrequest` high 3 cycles -> `write_req` held 4 cycles, `write_data`=0xCAFE_F00D, `cpu_done` after 5 cycles.
- `cpu_req` held high for 20 cycles after done -> exactly one bus request; a second request is issued only after `cpu_req` drops and rises again.
- `cpu_addr`=0x0800_0000 read -> no `read_req`, `cpu_done` with `cpu_err`=1, `cpu_rdata`=0xDEAD_BEEF.
- `TIMEOUT`=8 with `read_valid` never asserted -> `cpu_done` and `cpu_err` on the cycle after the counter hits 8; `read_req` low afterwards; a late `read_valid` is ignored.
- `rst` pulsed while in `RD_WAIT` -> all outputs 0 asynchronously, state `IDLE`, and the next read completes normally.
